ik_job_sequencer: RTL

//  Queues (x,y) target points from the trajectory front end and checks each one against the reachable annulus.

---
 rtl/ik_job_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ik_job_sequencer.sv
// IK job sequencer: queues (x,y) targets, rejects points outside the reachable annulus,
// runs one job at a time on the shared angle core with a hang timeout, returns th1/th2 + status.
module ik_job_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [28:0] REACH_MAX_SQ   = 29'd67108864,
  parameter logic [28:0] REACH_MIN_SQ   = 29'd0,
  parameter int unsigned ABORT_CYCLES   = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          tgt_valid,
  output logic                          tgt_ready,
  input  logic [13:0]                   tgt_x,
  input  logic [13:0]                   tgt_y,
  output logic                          calc_enable,
  output logic                          calc_reset,
  output logic [13:0]                   calc_x,
  output logic [13:0]                   calc_y,
  input  logic                          calc_done,
  input  logic [12:0]                   calc_th1,
  input  logic [12:0]                   calc_th2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [12:0]                   out_th1,
  output logic [12:0]                   out_th2,
  output logic [1:0]                    out_status,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMAX = (TIMEOUT_CYCLES > ABORT_CYCLES) ? TIMEOUT_CYCLES : ABORT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX) + 1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_UNREACH = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT_LOW, S_WAIT_HIGH, S_RESULT, S_ABORT
  } state_e;

  logic [13:0]   mem_x [FIFO_DEPTH];
  logic [13:0]   mem_y [FIFO_DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [13:0]   cx_q, cx_d, cy_q, cy_d;
  logic [12:0]   th1_q, th1_d, th2_q, th2_d;
  logic [1:0]    status_q, status_d;
  logic          tgt_ready_q, tgt_ready_d;
  logic          calc_enable_q, calc_enable_d;
  logic          calc_reset_q, calc_reset_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          push_c, pop_c;
  logic [28:0]   r2_c;

  assign push_c = tgt_valid && tgt_ready_q;
  // 14-bit squares fit in 28 bits, so the 29-bit sum never truncates
  assign r2_c   = 29'(cx_q) * 29'(cx_q) + 29'(cy_q) * 29'(cy_q);

  // Queue storage needs no reset: entries are only read when counted valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_x[wr_q] <= tgt_x;
      mem_y[wr_q] <= tgt_y;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      wr_q          <= '0;
      rd_q          <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      th1_q         <= '0;
      th2_q         <= '0;
      status_q      <= '0;
      tgt_ready_q   <= 1'b1;
      calc_enable_q <= 1'b0;
      calc_reset_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      th1_q         <= th1_d;
      th2_q         <= th2_d;
      status_q      <= status_d;
      tgt_ready_q   <= tgt_ready_d;
      calc_enable_q <= calc_enable_d;
      calc_reset_q  <= calc_reset_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    timer_d  = timer_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    th1_d    = th1_q;
    th2_d    = th2_q;
    status_d = status_q;
    pop_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          cx_d    = mem_x[rd_q];
          cy_d    = mem_y[rd_q];
          rd_d    = rd_q + AW'(1);
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((r2_c > REACH_MAX_SQ) || (r2_c < REACH_MIN_SQ)) begin
          status_d = ST_UNREACH;
          th1_d    = '0;
          th2_d    = '0;
          state_d  = S_RESULT;
        end else begin
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT_LOW;
      end
      // Timeout is checked first here: a done still high at this point is stale
      S_WAIT_LOW: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_ABORT;
        end else if (!calc_done) begin
          state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        timer_d = timer_q + TW'(1);
        if (calc_done) begin
          th1_d    = calc_th1;
          th2_d    = calc_th2;
          status_d = ST_OK;
          state_d  = S_RESULT;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(ABORT_CYCLES - 1)) begin
          status_d = ST_TIMEOUT;
          th1_d    = '0;
          th2_d    = '0;
          state_d  = S_RESULT;
        end
      end
      S_RESULT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_d          = push_c ? (wr_q + AW'(1)) : wr_q;
    count_d       = count_q + CW'(push_c) - CW'(pop_c);
    tgt_ready_d   = (count_d < CW'(FIFO_DEPTH));
    // Registered outputs are decoded from the next state so they align with it
    calc_enable_d = (state_d == S_LAUNCH);
    calc_reset_d  = (state_d == S_ABORT);
    out_valid_d   = (state_d == S_RESULT);
    busy_d        = (state_d != S_IDLE);
  end

  assign tgt_ready   = tgt_ready_q;
  assign calc_enable = calc_enable_q;
  assign calc_reset  = calc_reset_q;
  assign calc_x      = cx_q;
  assign calc_y      = cy_q;
  assign out_valid   = out_valid_q;
  assign out_th1     = th1_q;
  assign out_th2     = th2_q;
  assign out_status  = status_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;

endmodule
